// File: rtl/mux4_arb_pkg.sv
// Shared constants, FSM state type and helpers for the 4-way round-robin mux arbiter.
// No logic of its own; zero latency.
// No flow control; types and constants only.
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Bits needed to hold values 0..n-1 (returns 0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// First set request bit at or after ptr, wrapping modulo 4.
// Purely combinational, zero latency.
// No flow control; found=0 when no request is set.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan ptr, ptr+1, ... wrapping; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a registered 4:1 data mux, with burst cap.
// Grant/ctrl registered one edge after request; valid/src tag one edge later to match mux output.
// Owner keeps the mux while requesting, up to BURST_MAX cycles; handoff is gapless.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int BURST_MAX = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_grant,
  output logic [SEL_W-1:0] o_ctrl,
  output logic             o_busy,
  output logic             o_data_valid,
  output logic [SEL_W-1:0] o_data_src
);

  localparam int CNT_W = clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] ctrl_q, ctrl_d;
  logic             data_valid_q;
  logic [SEL_W-1:0] data_src_q;

  logic [SEL_W-1:0] scan_ptr;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  // While granted the only scan that matters is the release rescan, which starts after the owner.
  assign scan_ptr = (state_q == GRANT) ? ctrl_q + SEL_W'(1) : ptr_q;

  rr_pick4 u_pick (
    .req   (i_req),
    .ptr   (scan_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state: keep, hand off, or go idle; ctrl holds its value when idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ctrl_d  = ctrl_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          grant_d = N_REQ'(1) << pick_idx;
          ctrl_d  = pick_idx;
          cnt_d   = CNT_ONE;
        end
      end
      GRANT: begin
        if (i_req[ctrl_q] && (cnt_q < CNT_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          ptr_d = ctrl_q + SEL_W'(1);
          if (pick_found) begin
            grant_d = N_REQ'(1) << pick_idx;
            ctrl_d  = pick_idx;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbitration state and grant/select outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Tag registers trail the grant by one edge, lining up with the mux output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_valid_q <= 1'b0;
      data_src_q   <= '0;
    end else begin
      data_valid_q <= |grant_q;
      data_src_q   <= ctrl_q;
    end
  end

  assign o_grant      = grant_q;
  assign o_ctrl       = ctrl_q;
  assign o_busy       = |grant_q;
  assign o_data_valid = data_valid_q;
  assign o_data_src   = data_src_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] grant, grant1;
  logic [1:0] ctrl, ctrl1;
  logic       busy, busy1;
  logic       dvld, dvld1;
  logic [1:0] dsrc, dsrc1;

  int tests_run;
  int tests_failed;

  // Registered 4:1 mux that the arbiter drives, used for the data-alignment scenario.
  logic [15:0] mux_in [4];
  logic [15:0] mux_q;

  mux4_rr_arbiter #(.BURST_MAX(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .o_grant      (grant),
    .o_ctrl       (ctrl),
    .o_busy       (busy),
    .o_data_valid (dvld),
    .o_data_src   (dsrc)
  );

  mux4_rr_arbiter #(.BURST_MAX(1)) dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .o_grant      (grant1),
    .o_ctrl       (ctrl1),
    .o_busy       (busy1),
    .o_data_valid (dvld1),
    .o_data_src   (dsrc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mux_q <= mux_in[ctrl];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mux_in[0] = 16'h0000;
    mux_in[1] = 16'h00ff;
    mux_in[2] = 16'hff00;
    mux_in[3] = 16'hffff;
    rst_n = 1'b0;
    req   = 4'b1111;

    // 1: reset with all requesting, then first grant and valid
    step();
    step();
    chk("rst_grant", 16'(grant), 16'h0);
    chk("rst_ctrl", 16'(ctrl), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_dvld", 16'(dvld), 16'h0);
    chk("rst_dsrc", 16'(dsrc), 16'h0);
    rst_n = 1'b1;
    step();
    chk("s1_grant", 16'(grant), 16'h1);
    chk("s1_ctrl", 16'(ctrl), 16'h0);
    chk("s1_busy", 16'(busy), 16'h1);
    chk("s1_dvld_early", 16'(dvld), 16'h0);
    step();
    chk("s1_dvld", 16'(dvld), 16'h1);
    chk("s1_dsrc", 16'(dsrc), 16'h0);

    // 2: sole requester re-granted gaplessly, count wraps 1..4
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("s2_grant%0d", i), 16'(grant), 16'h4);
      chk($sformatf("s2_cnt%0d", i), 16'(dut.cnt_q), 16'((i % 4) + 1));
    end

    // 3: full load, 4-cycle bursts in rotation; BURST_MAX=1 rotates every cycle
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("s3_grant%0d", i), 16'(grant), 16'(4'b0001 << ((i / 4) % 4)));
      chk($sformatf("s3_b1_grant%0d", i), 16'(grant1), 16'(4'b0001 << (i % 4)));
      chk($sformatf("s3_ctrl%0d", i), 16'(ctrl), 16'((i / 4) % 4));
    end

    // 4: early release hands off without an idle cycle
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("s4_own0_%0d", i), 16'(grant), 16'h1);
    end
    req = 4'b0010;
    step();
    chk("s4_handoff", 16'(grant), 16'h2);
    chk("s4_busy", 16'(busy), 16'h1);
    step();
    chk("s4_hold", 16'(grant), 16'h2);

    // 5: data alignment with the registered mux
    do_reset();
    req = 4'b1000;
    step();
    chk("s5_grant", 16'(grant), 16'h8);
    chk("s5_ctrl", 16'(ctrl), 16'h3);
    step();
    chk("s5_data", mux_q, 16'hffff);
    chk("s5_dsrc", 16'(dsrc), 16'h3);
    chk("s5_dvld", 16'(dvld), 16'h1);
    req = 4'b0000;
    step();
    chk("s5_rel_grant", 16'(grant), 16'h0);
    chk("s5_rel_ctrl_hold", 16'(ctrl), 16'h3);
    chk("s5_rel_dvld_lag", 16'(dvld), 16'h1);
    step();
    chk("s5_dvld_off", 16'(dvld), 16'h0);

    // 6: asynchronous reset mid-burst, then priority restarts at 0
    do_reset();
    req = 4'b0100;
    step();
    step();
    chk("s6_owner", 16'(grant), 16'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_grant", 16'(grant), 16'h0);
    chk("s6_async_ctrl", 16'(ctrl), 16'h0);
    chk("s6_async_busy", 16'(busy), 16'h0);
    chk("s6_async_dvld", 16'(dvld), 16'h0);
    chk("s6_async_dsrc", 16'(dsrc), 16'h0);
    req = 4'b1100;
    step();
    rst_n = 1'b1;
    step();
    chk("s6_regrant", 16'(grant), 16'h4);
    chk("s6_regrant_ctrl", 16'(ctrl), 16'h2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
